// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module   : serial_arith_pkg
// Brief    : Shared types and constants for the bit-serial arithmetic units.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit counter width for a given operand width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor_bit.sv
// ============================================================================
// Module   : full_subtractor_bit
// Brief    : Single-bit combinational full subtractor (a - b - bin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor_4bit.sv
// ============================================================================
// Module   : serial_subtractor_4bit
// Brief    : Bit-serial D = A - B - Bin, LSB first, start/done handshake.
//            Define SERIAL_SUB_SIGNED_OVF_EN to add the registered ovf output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor_4bit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               brw_q, brw_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bout_q, bout_d;
  logic               bit_diff, bit_brw;
  logic [WIDTH-1:0]   res_shift;
  logic               load;

  full_subtractor_bit u_fsb (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q),
    .diff (bit_diff),
    .bout (bit_brw)
  );

  assign res_shift = {bit_diff, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    load    = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: load = start;
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        brw_d = bit_brw;
        res_d = res_shift;
        cnt_d = cnt_q + 1'b1;
        // Results are published only on the final bit so D never shows partial values.
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          d_d     = res_shift;
          bout_d  = bit_brw;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
`endif
        end
      end
      DONE: begin
        load    = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = SHIFT;
      a_d     = A;
      b_d     = B;
      brw_d   = Bin;
      cnt_d   = '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_d = A[WIDTH-1];
      b_msb_d = B[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign D    = d_q;
  assign Bout = bout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_4bit.sv
// ============================================================================
// Module   : tb_serial_subtractor_4bit
// Brief    : Scoreboard bench for serial_subtractor_4bit (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor_4bit;

  typedef struct packed {
    logic [3:0] d;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic [3:0] D;
  logic       Bout;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic       ovf;
`endif

  exp_t exp_q[$];
  int   n_total;
  int   n_fail;

  serial_subtractor_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with D=%0h expected no done", D);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_D", 32'(D), 32'(e.d));
        chk("result_Bout", 32'(Bout), 32'(e.bout));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("result_ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Caller sits at a negedge; drives a start for one edge and returns at the next negedge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          input logic [3:0] ed, input logic eb, input logic eo,
                          input bit expect_done);
    exp_t e;
    A = a; B = b; Bin = bin; start = 1'b1;
    if (expect_done) begin
      e.d = ed; e.bout = eb; e.ovf = eo;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_total++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  initial begin
    n_total = 0;
    n_fail  = 0;
    rst_n = 1'b0; start = 1'b1; A = 4'd6; B = 4'd1; Bin = 1'b0;

    // Reset held with start asserted.
    repeat (2) @(negedge clk);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_Bout", 32'(Bout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic op with exact latency: busy for 4 cycles, then done.
    start_op(4'd6, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_nodone", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("lat_done", 32'(done), 32'd1);
    chk("lat_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_pulse_1cyc", 32'(done), 32'd0);

    // Borrow / wrap-around.
    start_op(4'd0, 4'd1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    @(negedge clk);
    chk("hold_D_idle", 32'(D), 32'd15);
    chk("hold_Bout_idle", 32'(Bout), 32'd1);

    // Abort: reset two cycles after an accepted start; no done may follow.
    start_op(4'd5, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_D", 32'(D), 32'd0);
    chk("abort_Bout", 32'(Bout), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_idle_D", 32'(D), 32'd0);

    // Fresh op after abort.
    start_op(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);

    start_op(4'd7, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);

    // Operand churn and a stray start while busy must not disturb the result.
    start_op(4'd12, 4'd5, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1);
    A = 4'd15; B = 4'd15; Bin = 1'b1;
    @(negedge clk);
    start = 1'b1; A = 4'd1; B = 4'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // Back-to-back: start in the DONE cycle.
    start_op(4'd9, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_D_hold", 32'(D), 32'd7);
    wait_done();
    @(negedge clk);

    // Signed overflow vectors (D/Bout checked in every build).
    start_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    start_op(4'd3, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor_4bit.md
Name: serial_subtractor_4bit

Overview:
- Bit-serial, multi-cycle subtractor computing D = A - B - Bin, LSB first, one bit per clock.
- Operand/result shape mirrors the team's 4-bit ripple adder, so the same stimulus style and value sets check both.
- Sits beside the adder as the "other direction" arithmetic unit; start/done handshake lets a controller sequence operations.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- A  input  WIDTH  minuend; captured on the accepting edge
- B  input  WIDTH  subtrahend; captured on the accepting edge
- Bin  input  1  borrow-in; captured on the accepting edge
- D  output  WIDTH  difference, registered
- Bout  output  1  borrow-out (1 when A < B + Bin, unsigned), registered
- busy  output  1  high while shifting
- done  output  1  one-cycle pulse; D/Bout valid

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. Assertion immediately forces all state and outputs to 0 and the state machine to IDLE.
- Reset values: D=0, Bout=0, busy=0, done=0.
- State machine: IDLE, SHIFT, DONE.
  - IDLE: if start=1, capture A, B and Bin into internal shift registers (Bin seeds the borrow flop). Clear the bit counter and go to SHIFT.
  - SHIFT: each edge processes bit 0 of the shift registers.
    - diff = a ^ b ^ brw
    - brw_next = (~a & b) | (~(a ^ b) & brw)
    - diff shifts into the MSB of the result register; operands shift right; counter increments.
    - After WIDTH edges, go to DONE.
  - DONE: done=1 for exactly this cycle. If start=1, accept new operands exactly as in IDLE and go to SHIFT (back-to-back operation); otherwise go to IDLE.
- Latency: with start accepted at edge E, done is high in the cycle following edge E+WIDTH. The WIDTH=4 cycle count from accept to done is 4.
- busy=1 exactly during SHIFT. start is ignored while busy; operand changes during SHIFT do not affect the result.
- D and Bout update only at the transition into DONE. They hold their value through IDLE until the next operation completes; no intermediate bits appear on D.
- Arithmetic is modulo 2^WIDTH. Bout is the final borrow flop value.
- Reset mid-operation aborts the operation. No done pulse is produced for the aborted operation.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- Defined: adds output ovf (1 bit), registered with D.
  - ovf = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), i.e. two's-complement overflow, using the captured operand MSBs.
  - Reset value 0.
- Undefined: port ovf is absent; no extra logic.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - default WIDTH constant
  - counter width as $clog2(WIDTH+1)
- One sub-module, full_subtractor_bit: combinational diff/borrow for a single bit. It is instantiated once in the datapath and is reusable by the verification model.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> D=0, Bout=0, busy=0, done=0. No operation starts until rst_n=1.
- Basic: A=6, B=1, Bin=0, pulse start -> busy high for 4 cycles, then done pulse with D=5, Bout=0.
- Borrow/wrap: A=0, B=1, Bin=0 -> D=15, Bout=1. Then A=7, B=3, Bin=1 -> D=3, Bout=0.
- Back-to-back: assert start in the DONE cycle with A=9, B=9, Bin=0 -> next done 4 cycles later with D=0, Bout=0. Also change A/B while busy -> result unaffected.
- Abort: pulse rst_n low 2 cycles after an accepted start (A=5, B=2) -> outputs 0 immediately, no done. A fresh op A=5, B=2 -> D=3.
- SERIAL_SUB_SIGNED_OVF_EN:
  - A=8, B=1 -> D=7, ovf=1, Bout=0.
  - A=3, B=1 -> ovf=0.
  - Without the macro, the bench compiles with no ovf port.
